// File: rtl/noc_params.sv
// Shared NoC parameters and types: flit labels, scheduler states, sizing.
package noc_params;

  localparam int unsigned VC_NUM  = 2;
  localparam int unsigned VC_SIZE = 8;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;

  // True for labels that may start a packet.
  function automatic logic is_head_label(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/input_vc_scheduler_round_robin_arbiter.sv
// Combinational round-robin arbiter; search starts one past the priority pointer.
module round_robin_arbiter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  // Position k steps after the pointer, wrapped to the request range.
  function automatic int unsigned wrap_idx(input logic [W-1:0] ptr, input int unsigned k);
    return (32'(ptr) + k) % N;
  endfunction

  // Pick the first requester in circular order after the pointer.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!any_o && req_i[W'(wrap_idx(ptr_i, k))]) begin
        any_o                          = 1'b1;
        gnt_o[W'(wrap_idx(ptr_i, k))]  = 1'b1;
        gnt_idx_o                      = W'(wrap_idx(ptr_i, k));
      end
    end
  end

endmodule

// File: rtl/input_vc_scheduler.sv
// Per-input-port VC read scheduler with wormhole locking.
// Optional protocol checker enabled by defining VC_SCHED_PROTOCOL_CHECK_EN.
module input_vc_scheduler
  import noc_params::*;
#(
  parameter int unsigned VC_NUM   = noc_params::VC_NUM,
  parameter int unsigned VC_SEL_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VC_NUM-1:0]   is_empty_i,
  input  flit_label_t         head_label_i [VC_NUM],
  input  logic [VC_NUM-1:0]   on_off_i,
  input  logic                grant_i,
  output logic                valid_o,
  output logic [VC_SEL_W-1:0] vc_sel_o,
  output logic [VC_NUM-1:0]   read_o,
  output logic                locked_o,
  output logic                error_o
);

  sched_state_t          state_q;
  logic [VC_SEL_W-1:0]   lock_vc_q;
  logic [VC_SEL_W-1:0]   last_vc_q;

  logic [VC_NUM-1:0]     elig_c;
  logic [VC_NUM-1:0]     arb_gnt_c;
  logic [VC_SEL_W-1:0]   arb_idx_c;
  logic                  arb_any_c;
  logic                  valid_c;
  logic [VC_SEL_W-1:0]   sel_c;
  logic [VC_NUM-1:0]     read_c;
  logic                  xfer_c;
  flit_label_t           sel_label_c;

  // A VC may start a packet when it holds a head flit and downstream is on.
  always_comb begin
    elig_c = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      elig_c[v] = ~is_empty_i[v] & on_off_i[v] & is_head_label(head_label_i[v]);
    end
  end

  round_robin_arbiter #(
    .N (VC_NUM),
    .W (VC_SEL_W)
  ) u_arb (
    .req_i     (elig_c),
    .ptr_i     (last_vc_q),
    .gnt_o     (arb_gnt_c),
    .gnt_idx_o (arb_idx_c),
    .any_o     (arb_any_c)
  );

  // Offer selection: arbiter when idle, locked VC inside a packet.
  always_comb begin
    valid_c = 1'b0;
    sel_c   = '0;
    read_c  = '0;
    if (state_q == IDLE) begin
      valid_c = arb_any_c;
      sel_c   = arb_idx_c;
    end else begin
      valid_c = ~is_empty_i[lock_vc_q] & on_off_i[lock_vc_q];
      sel_c   = lock_vc_q;
    end
    if (rst) begin
      valid_c = 1'b0;
    end
    xfer_c = valid_c & grant_i;
    if (xfer_c) begin
      read_c = (state_q == IDLE) ? arb_gnt_c : (VC_NUM'(1) << lock_vc_q);
    end
  end

  assign sel_label_c = head_label_i[sel_c];
  assign valid_o     = valid_c;
  assign vc_sel_o    = sel_c;
  assign read_o      = read_c;
  assign locked_o    = (state_q == LOCKED) & ~rst;

  // Wormhole FSM: lock on HEAD, release on TAIL, advance pointer per packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_vc_q <= '0;
      last_vc_q <= VC_SEL_W'(VC_NUM - 1);
    end else if (xfer_c) begin
      unique case (state_q)
        IDLE: begin
          if (sel_label_c == HEAD) begin
            state_q   <= LOCKED;
            lock_vc_q <= sel_c;
          end else begin
            last_vc_q <= sel_c;
          end
        end
        LOCKED: begin
          if (sel_label_c == TAIL) begin
            state_q   <= IDLE;
            last_vc_q <= lock_vc_q;
          end
        end
      endcase
    end
  end

`ifdef VC_SCHED_PROTOCOL_CHECK_EN
  logic err_q;
  logic err_d;
  logic bad_front_c;

  // Sticky error on a non-head front while idle or a head transferred while locked.
  always_comb begin
    bad_front_c = 1'b0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (!is_empty_i[v] && !is_head_label(head_label_i[v])) begin
        bad_front_c = 1'b1;
      end
    end
    err_d = err_q
          | ((state_q == IDLE) & bad_front_c)
          | ((state_q == LOCKED) & xfer_c & is_head_label(sel_label_c));
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_vc_scheduler.sv
// Scoreboard bench for input_vc_scheduler: buffer queues plus a packet-level reference model.
module tb_input_vc_scheduler;
  import noc_params::*;

  localparam int unsigned N = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     is_empty;
  flit_label_t      head_label [N];
  logic [N-1:0]     on_off;
  logic             grant;
  logic             valid;
  logic [0:0]       vc_sel;
  logic [N-1:0]     read;
  logic             locked;
  logic             error;

  input_vc_scheduler #(
    .VC_NUM   (N),
    .VC_SEL_W (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .is_empty_i   (is_empty),
    .head_label_i (head_label),
    .on_off_i     (on_off),
    .grant_i      (grant),
    .valid_o      (valid),
    .vc_sel_o     (vc_sel),
    .read_o       (read),
    .locked_o     (locked),
    .error_o      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    int         sel;
    logic [1:0] rd;
    logic       lk;
    logic       er;
  } exp_t;

  exp_t        exp_q [$];
  flit_label_t bufq  [N][$];
  flit_label_t src   [N][$];

  int checks = 0;
  int errors = 0;

  // Reference model: packet ownership, round-robin memory, sticky error.
  bit          m_in_pkt = 0;
  int          m_owner  = 0;
  int          m_last   = N - 1;
  bit          m_err    = 0;
  bit          p_xfer;
  int          p_v;
  flit_label_t p_label;
  bit          p_err;
  bit          feed_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare each presented output against the queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid_o", 32'(valid), 32'(e.v));
      chk("read_o", 32'(read), 32'(e.rd));
      chk("locked_o", 32'(locked), 32'(e.lk));
      chk("error_o", 32'(error), 32'(e.er));
      if (e.v) chk("vc_sel_o", 32'(vc_sel), 32'(e.sel));
    end
  end

  function automatic bit starts_pkt(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  // Drive buffer fronts and predict this cycle's offer from packet-level rules.
  task automatic drive_and_predict();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      is_empty[i]   = (bufq[i].size() == 0);
      head_label[i] = (bufq[i].size() > 0) ? bufq[i][0] : BODY;
    end
    e.v = 0; e.sel = 0; e.rd = '0; e.lk = 0; e.er = m_err;
    p_xfer = 0; p_v = 0; p_label = BODY; p_err = m_err;
    if (!rst) begin
      e.lk = m_in_pkt;
      if (!m_in_pkt) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!e.v && bufq[c].size() > 0 && on_off[c] && starts_pkt(bufq[c][0])) begin
            e.v   = 1;
            e.sel = c;
          end
        end
      end else begin
        e.sel = m_owner;
        e.v   = (bufq[m_owner].size() > 0) && on_off[m_owner];
      end
      if (e.v && grant) begin
        p_xfer  = 1;
        p_v     = e.sel;
        p_label = bufq[e.sel][0];
        e.rd    = 2'(1 << e.sel);
      end
`ifdef VC_SCHED_PROTOCOL_CHECK_EN
      if (!m_in_pkt) begin
        for (int i = 0; i < N; i++)
          if (bufq[i].size() > 0 && !starts_pkt(bufq[i][0])) p_err = 1;
      end else if (p_xfer && starts_pkt(p_label)) begin
        p_err = 1;
      end
`endif
    end
    exp_q.push_back(e);
  endtask

  // Apply the cycle's transfer to buffers and model, then trickle in new flits.
  task automatic commit();
    if (rst) begin
      m_in_pkt = 0;
      m_last   = N - 1;
      m_err    = 0;
    end else begin
      if (p_xfer) begin
        void'(bufq[p_v].pop_front());
        if (!m_in_pkt) begin
          if (p_label == HEAD) begin
            m_in_pkt = 1;
            m_owner  = p_v;
          end else begin
            m_last = p_v;
          end
        end else if (p_label == TAIL) begin
          m_in_pkt = 0;
          m_last   = m_owner;
        end
      end
      m_err = p_err;
    end
    if (feed_en) begin
      for (int i = 0; i < N; i++) begin
        if (src[i].size() == 0) begin
          int len;
          len = $urandom_range(4, 1);
          if (len == 1) src[i].push_back(HEADTAIL);
          else begin
            src[i].push_back(HEAD);
            for (int b = 0; b < len - 2; b++) src[i].push_back(BODY);
            src[i].push_back(TAIL);
          end
        end
        if ($urandom_range(1, 0) == 1 && bufq[i].size() < 4)
          bufq[i].push_back(src[i].pop_front());
      end
    end
  endtask

  task automatic step();
    drive_and_predict();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic load(input int vc, input flit_label_t l);
    bufq[vc].push_back(l);
  endtask

  initial begin
    rst   = 1'b1;
    on_off = 2'b11;
    grant = 1'b1;
    for (int i = 0; i < N; i++) begin
      is_empty[i]   = 1'b1;
      head_label[i] = BODY;
    end
    load(0, HEADTAIL); load(0, HEADTAIL);
    load(1, HEADTAIL); load(1, HEADTAIL);
    @(posedge clk);
    #1;

    // Reset held with traffic present, then round-robin over HEADTAIL flits.
    repeat (5) step();
    rst = 1'b0;
    repeat (5) step();

    // Wormhole lock: VC0 packet fully before VC1.
    load(0, HEAD); load(0, BODY); load(0, TAIL); load(1, HEADTAIL);
    repeat (6) step();

    // Downstream off mid-packet stalls VC0 while VC1 waits.
    load(0, HEAD); load(0, BODY); load(0, TAIL);
    load(1, HEADTAIL); load(1, HEADTAIL);
    step();
    on_off = 2'b10;
    repeat (3) step();
    on_off = 2'b11;
    repeat (6) step();

    // Grant withheld on a single eligible VC.
    load(1, HEADTAIL);
    grant = 1'b0;
    repeat (4) step();
    grant = 1'b1;
    repeat (2) step();

    // Randomized traffic with partial buffers and flow control.
    feed_en = 1;
    repeat (3000) begin
      on_off[0] = ($urandom_range(3, 0) != 0);
      on_off[1] = ($urandom_range(3, 0) != 0);
      grant     = ($urandom_range(3, 0) != 0);
      step();
    end
    feed_en = 0;

`ifdef VC_SCHED_PROTOCOL_CHECK_EN
    // BODY at the front while idle raises a sticky error until reset.
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      bufq[i].delete();
      src[i].delete();
    end
    on_off = 2'b11;
    grant  = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    load(0, BODY);
    repeat (4) step();
    bufq[0].delete();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
`endif

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
